// File: rtl/contador_bits_param_if.sv
// contador_bits_param_if
// Groups the request/result signals of the serial bit-statistics unit.
//
// Handshake: 'start' is a request that the unit takes only while it is not
// busy (OCIOSO or PRONTO). The cycle in which it is taken also captures A
// and modo. 'pronto' goes high when the result is ready. 'resultado' is then
// valid and stays stable until the next request is taken. 'ocupado' is high
// for the whole counting phase, and requests made during that phase are
// ignored.
//
// Signals:
//   start     request a new operation (master -> unit)
//   A         WIDTH-bit operand (master -> unit)
//   modo      00 ones, 01 zeros, 10 trailing zeros, 11 same as 00
//   resultado CW-bit count, valid while pronto=1 (unit -> master)
//   pronto    unit holds a finished result
//   ocupado   unit is counting
//   estado    debug view of the control FSM: 0 OCIOSO, 1 CONTA, 2 PRONTO
interface contador_bits_param_if #(
  parameter int WIDTH = 16
) ();
  localparam int CW = $clog2(WIDTH + 1);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [1:0]       modo;
  logic [CW-1:0]    resultado;
  logic             pronto;
  logic             ocupado;
  logic [1:0]       estado;

  modport master (
    output start, A, modo,
    input  resultado, pronto, ocupado, estado
  );

  modport slave (
    input  start, A, modo,
    output resultado, pronto, ocupado, estado
  );
endinterface

// File: rtl/contador_bits_param.sv
// contador_bits_param
// Serial bit-statistics unit. It counts the ones, zeros or trailing zeros of
// a WIDTH-bit operand, one bit per clock. A control FSM drives a
// shift-right data register and an increment counter. The count stops early
// as soon as no remaining bit can change the result.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high; drops any operation in flight
//   bus    contador_bits_param_if.slave (start, A, modo in;
//          resultado, pronto, ocupado, estado out)
module contador_bits_param #(
  parameter  int WIDTH = 16,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  contador_bits_param_if.slave bus
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CONTA  = 2'd1,
    PRONTO = 2'd2
  } estado_t;

  estado_t          estado, estado_n;
  logic [WIDTH-1:0] reg_a, reg_a_n;
  logic [1:0]       modo_r, modo_r_n;
  logic [CW-1:0]    cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= OCIOSO;
      reg_a  <= '0;
      modo_r <= 2'b00;
      cnt    <= '0;
    end else begin
      estado <= estado_n;
      reg_a  <= reg_a_n;
      modo_r <= modo_r_n;
      cnt    <= cnt_n;
    end
  end

  always_comb begin
    estado_n = estado;
    reg_a_n  = reg_a;
    modo_r_n = modo_r;
    cnt_n    = cnt;
    case (estado)
      OCIOSO, PRONTO: begin
        if (bus.start) begin
          // Counting zeros is counting ones of the inverted operand.
          reg_a_n  = (bus.modo == 2'b01) ? ~bus.A : bus.A;
          modo_r_n = bus.modo;
          cnt_n    = '0;
          estado_n = CONTA;
        end
      end
      CONTA: begin
        if (modo_r == 2'b10) begin
          if (reg_a == '0) begin
            // An all-zero operand has no terminating one.
            cnt_n    = CW'(WIDTH);
            estado_n = PRONTO;
          end else if (reg_a[0]) begin
            estado_n = PRONTO;
          end else begin
            cnt_n   = cnt + CW'(1);
            reg_a_n = reg_a >> 1;
          end
        end else begin
          // Once the register is empty, no ones are left to count.
          if (reg_a == '0) begin
            estado_n = PRONTO;
          end else begin
            cnt_n   = cnt + CW'(reg_a[0]);
            reg_a_n = reg_a >> 1;
          end
        end
      end
      default: estado_n = OCIOSO;
    endcase
  end

  assign bus.resultado = cnt;
  assign bus.pronto    = (estado == PRONTO);
  assign bus.ocupado   = (estado == CONTA);
  assign bus.estado    = estado;

endmodule
